// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by uart_tx_scheduler and its arbiter.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int NUM_REQ_DEF = 2;
  localparam int BYTES_PER_WORD_DEF = 4;
  localparam int DATA_W_DEF = BYTE_W * BYTES_PER_WORD_DEF;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-of-N pick, round-robin from ptr by default.
// With UART_SCHED_FIXED_PRIO_EN defined the lowest requesting index wins and ptr is ignored.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  int j;
  always_comb begin
    win = '0;
    idx = '0;
    j = 0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int k = N - 1; k >= 0; k--) begin
`ifdef UART_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr) + k) % N;
`endif
      if (req[j]) begin
        win = '0;
        win[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates NUM_REQ word senders onto a byte transmitter, LSB byte first.
// Define UART_SCHED_FIXED_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int DATA_W         = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic                        tx_start,
  output logic [BYTE_W-1:0]           tx_byte,
  input  logic                        tx_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BI = BYTES_PER_WORD > 1 ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BI-1:0] LAST = BI'(BYTES_PER_WORD - 1);

  state_t              state;
  logic [DATA_W-1:0]   word;
  logic [IW-1:0]       owner, ptr, widx;
  logic [BI-1:0]       idx;
  logic [NUM_REQ-1:0]  win;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .win(win),
    .idx(widx)
  );

`ifdef UART_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (state == ST_FINISH) ptr <= owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word     <= '0;
      owner    <= '0;
      idx      <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_byte  <= '0;
    end else begin
      grant    <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: if (|req) begin
          word  <= data_in[widx*DATA_W +: DATA_W];
          owner <= widx;
          idx   <= '0;
          grant <= win;
          busy  <= 1'b1;
          state <= ST_LOAD;
        end
        ST_LOAD: if (!tx_busy) begin
          tx_byte  <= word[BYTE_W*idx +: BYTE_W];
          tx_start <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND:      state <= ST_WAIT_ACK;
        ST_WAIT_ACK:  if (tx_busy) state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!tx_busy) begin
          idx   <= idx == LAST ? idx : idx + 1'b1;
          state <= idx == LAST ? ST_FINISH : ST_LOAD;
        end
        ST_FINISH: begin
          done  <= NUM_REQ'(1) << owner;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized and directed checks of uart_tx_scheduler against a word-level model.
module tb_uart_tx_scheduler;
  localparam int N = 2;
  logic clk = 1'b0, rst_n = 1'b0, tx_busy = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*32-1:0] data_in = '0;
  logic [N-1:0] grant, done;
  logic busy, tx_start;
  logic [7:0] tx_byte;
  int tests = 0, failed = 0, cyc = 0, busy_len = 10, mptr = 0, lc = 0;
  bit force_busy = 1'b0;
  bit [N-1:0] sticky = '0;
  logic [N-1:0] g_q[$], d_q[$], eg_q[$];
  logic [7:0] b_q[$], eb_q[$];
  int gc_q[$], dc_q[$], sc_q[$];

  always #5 clk = ~clk;

  uart_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .grant(grant), .done(done),
    .busy(busy), .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy)
  );

  // Event log, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (|grant) begin g_q.push_back(grant); gc_q.push_back(cyc); end
    if (|done) begin d_q.push_back(done); dc_q.push_back(cyc); end
    if (tx_start) begin b_q.push_back(tx_byte); sc_q.push_back(cyc); end
  end

  // Requesters: drop req after grant and scribble over their word to prove it was latched.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) if (grant[i]) begin
      data_in[i*32 +: 32] = '1;
      if (!sticky[i]) req[i] = 1'b0;
    end
  end

  // Byte transmitter: busy for busy_len cycles per started byte, or held busy on demand.
  initial forever begin
    @(negedge clk);
    if (force_busy) tx_busy = 1'b1;
    else if (tx_start) begin
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      tx_busy = 1'b0;
    end else tx_busy = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_word(input int w, input logic [31:0] wd);
    eg_q.push_back(N'(1) << w);
    for (int b = 0; b < 4; b++) eb_q.push_back(wd[8*b +: 8]);
    mptr = (w + 1) % N;
  endfunction

  function automatic int pick(input logic [N-1:0] m);
`ifdef UART_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (m[k]) return k;
`else
    for (int k = 0; k < N; k++) if (m[(mptr + k) % N]) return (mptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic launch(input logic [N-1:0] m, input logic [31:0] w0, input logic [31:0] w1);
    logic [N-1:0] rem;
    int w;
    @(negedge clk);
    #1;
    g_q.delete(); d_q.delete(); eg_q.delete(); b_q.delete(); eb_q.delete();
    gc_q.delete(); dc_q.delete(); sc_q.delete();
    data_in = {w1, w0};
    rem = m;
    while (rem != 0) begin
      w = pick(rem);
      expect_word(w, w == 1 ? w1 : w0);
      rem[w] = 1'b0;
    end
    lc = cyc;
    req = m;
  endtask

  task automatic finish(input int n, input bit lat);
    int t = 0;
    while (d_q.size() < n && t < 3000) begin @(negedge clk); t++; end
    chk("done_timeout", 64'(t < 3000), 64'd1);
    @(negedge clk);
    #1;
    chk("busy_after", 64'(busy), 64'd0);
    chk("grant_count", 64'(g_q.size()), 64'(eg_q.size()));
    chk("done_count", 64'(d_q.size()), 64'(eg_q.size()));
    chk("byte_count", 64'(b_q.size()), 64'(eb_q.size()));
    foreach (eg_q[i]) if (i < g_q.size()) chk("grant_order", 64'(g_q[i]), 64'(eg_q[i]));
    foreach (eg_q[i]) if (i < d_q.size()) chk("done_order", 64'(d_q[i]), 64'(eg_q[i]));
    foreach (eb_q[i]) if (i < b_q.size()) chk("tx_byte", 64'(b_q[i]), 64'(eb_q[i]));
    if (lat && gc_q.size() > 0 && sc_q.size() > 0) begin
      chk("grant_latency", 64'(gc_q[0] - lc), 64'd1);
      chk("start_latency", 64'(sc_q[0] - gc_q[0]), 64'd1);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
    chk({tag, "_tx_byte"}, 64'(tx_byte), 64'd0);
  endtask

  initial begin
    int t, rc;
    logic [N-1:0] m;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    // Single word, LSB first
    launch(2'b01, 32'hA1B2C3D4, 32'h0);
    finish(1, 1'b1);
    if (b_q.size() > 3) chk("first_byte_lsb", 64'(b_q[0]), 64'hD4);
    // Two rounds of contention
    launch(2'b11, 32'h11111111, 32'h22222222);
    finish(2, 1'b1);
    launch(2'b11, 32'h11111111, 32'h22222222);
    finish(2, 1'b1);
    // Transmitter busy when LOAD is reached
    force_busy = 1'b1;
    launch(2'b10, $urandom, $urandom);
    repeat (20) @(negedge clk);
    #1;
    chk("no_start_while_busy", 64'(b_q.size()), 64'd0);
    chk("busy_in_load", 64'(busy), 64'd1);
    force_busy = 1'b0;
    rc = cyc;
    finish(1, 1'b0);
    if (sc_q.size() > 0) chk("start_after_busy_fall", 64'(sc_q[0] - (rc + 1)), 64'd1);
    // Asynchronous reset during the second byte
    launch(2'b01, 32'hA1B2C3D4, 32'h0);
    t = 0;
    while (b_q.size() < 2 && t < 500) begin @(negedge clk); t++; end
    chk("reach_byte2", 64'(t < 500), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    repeat (busy_len + 5) @(negedge clk);
    chk("no_done_on_abort", 64'(d_q.size()), 64'd0);
    #1;
    rst_n = 1'b1;
    mptr = 0;
    launch(2'b10, 32'h0, 32'h5A6B7C8D);
    finish(1, 1'b1);
    // Sticky request: held through done, re-granted straight away
    sticky = 2'b10;
    launch(2'b10, 32'h0, 32'hCAFEF00D);
    t = 0;
    while (d_q.size() < 1 && t < 3000) begin @(negedge clk); t++; end
    chk("sticky_first_done", 64'(t < 3000), 64'd1);
    sticky = '0;
    expect_word(1, 32'hFFFFFFFF);
    finish(2, 1'b0);
    if (gc_q.size() > 1 && dc_q.size() > 0) chk("sticky_regrant", 64'(gc_q[1] - dc_q[0]), 64'd1);
    // Random masks, words and transmitter speeds
    for (int r = 0; r < 10; r++) begin
      m = N'($urandom_range(1, 3));
      busy_len = $urandom_range(2, 12);
      launch(m, $urandom, $urandom);
      finish($countones(m), 1'b1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
